dual_core_mem_arbiter: RTL
==========================

Name: dual_core_mem_arbiter

Overview:
- Shared-memory arbiter between the two multicycle MIPS cores and the single-port byte-wide unified instruction/data memory.
- Sits directly downstream of each core's control FSM and datapath. It consumes each core's memread/memwrite, address and write data, and returns read data plus a completion ack.
- Serialises accesses with round-robin fairness. A core's FSM holds in its current state until ack.

Parameters:
- AW, 8, address width in bits.
- DW, 8, data width in bits (byte memory).
- MEM_LAT, 1, memory access cycles per transaction; legal range 1..4.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- c0_req  input  1  core 0 access request; held high until c0_ack.
- c0_we  input  1  core 0 write enable (1 = write, 0 = read); valid while c0_req is high.
- c0_addr  input  AW  core 0 address.
- c0_wdata  input  DW  core 0 write data.
- c0_rdata  output  DW  core 0 read data; valid from c0_ack onward.
- c0_ack  output  1  core 0 completion pulse, one cycle wide.
- c1_req, c1_we, c1_addr, c1_wdata, c1_rdata, c1_ack: identical set for core 1.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; valid in the final cycle of an access.

Behaviour:
- Reset (async): state = IDLE, last_grant = 1, cnt = 0.
  - All outputs are 0, including c*_rdata.
  - Reset mid-access aborts the access silently: no ack, and c*_rdata is cleared.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled every cycle.
  - Only one requesting core: grant it.
  - Both requesting: grant the core != last_grant.
  - On grant, register grant id, we, addr and wdata, set cnt = MEM_LAT-1, and go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_en = 1; mem_we, mem_addr and mem_wdata are driven from the latched values, stable for all MEM_LAT cycles.
  - cnt decrements each cycle.
  - When cnt == 0:
    - On a read, capture mem_rdata into the granted core's rdata register.
    - last_grant <= grant id.
    - Go to DONE.
- DONE:
  - The granted core's ack = 1 for exactly one cycle; mem_en = 0.
  - All req inputs are ignored in this cycle.
  - Next state is IDLE.
- Latency:
  - req first high in cycle 0 while in IDLE → mem_en in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1.
  - The minimum request-to-request period for one core is MEM_LAT+2 cycles.
- Read data:
  - c*_rdata holds its value until that core's next read completes.
  - Writes do not alter c*_rdata.
  - The other core's rdata is never disturbed.
- Protocol:
  - A core must drop or renew req in the cycle after ack. A req high in IDLE is always a new request.
  - If a core drops req before its ack, the latched access still completes and is acked.
- Starvation-free: under continuous contention, grants alternate c0, c1, c0, ...
- Ack exclusivity:
  - At most one of c0_ack/c1_ack is high in any cycle.
  - mem_en is never high in IDLE or DONE.
- Widths: no arithmetic on addresses or data; cnt is 2 bits.

Test Plan:
- Core 0 read, single requester: MEM_LAT=1, mem[0x10]=0xA5, c0 read 0x10 → mem_en high for 1 cycle with mem_addr=0x10, mem_we=0; c0_ack in cycle 2; c0_rdata=0xA5; c1_ack stays 0.
- Contention after reset: c0 and c1 both request in the same cycle (c0 write 0x20←0x3C, c1 read 0x20) → c0 is served first (last_grant=1 at reset), then c1 reads 0x3C; c0_ack precedes c1_ack by MEM_LAT+2 cycles.
- Fairness under continuous load: both cores hold req high for 6 transactions → grant order c0, c1, c0, c1, c0, c1; no two acks in the same cycle.
- Latency parameter: MEM_LAT=3, c1 read 0x7F (mem=0x11) → mem_en high for exactly 3 cycles with stable address; c1_ack in cycle 4; c1_rdata=0x11.
- Reset mid-access: MEM_LAT=3, assert reset during the 2nd ACCESS cycle → mem_en drops immediately; no ack; rdata=0x00; after release, a new c0 request completes normally.
- Write isolation: c0 reads 0x05 (0x9E), then c1 writes 0x05←0x42 → c0_rdata stays 0x9E; c1_rdata unchanged; a subsequent c0 read returns 0x42.

Source files
------------

// File: rtl/dual_core_mem_arbiter_if.sv
// Bundle of both core request ports and the memory port of the shared-memory arbiter.
// "master" is the arbiter's view (it masters the memory); "slave" is the cores/memory side.
interface dual_core_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          c0_req;
  logic          c0_we;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata;
  logic [DW-1:0] c0_rdata;
  logic          c0_ack;

  logic          c1_req;
  logic          c1_we;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata;
  logic [DW-1:0] c1_rdata;
  logic          c1_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    output c0_rdata, c0_ack,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c1_rdata, c1_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output c0_req, c0_we, c0_addr, c0_wdata,
    input  c0_rdata, c0_ack,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c1_rdata, c1_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter giving two multicycle cores serialised access to one byte-wide memory.
// Each access is IDLE (grant) -> ACCESS (MEM_LAT cycles) -> DONE (one-cycle ack).
module dual_core_mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  dual_core_mem_arbiter_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic               grant_reg;
  logic               last_grant_reg;
  logic               we_reg;
  logic [AW-1:0]      addr_reg;
  logic [DW-1:0]      wdata_reg;
  logic [1:0]         cnt_reg;
  logic [1:0][DW-1:0] rdata_reg;

  logic [1:0] req;
  logic       pick;
  logic       access_last;

  assign req         = {bus.c1_req, bus.c0_req};
  assign access_last = (state_reg == ACCESS) && (cnt_reg == 2'd0);

  // With both cores requesting, the one not served last time wins.
  always_comb begin
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant_reg;
      default: pick = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req) state_next = ACCESS;
      ACCESS:  if (cnt_reg == 2'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= 2'd0;
      rdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_reg <= pick;
            we_reg    <= pick ? bus.c1_we    : bus.c0_we;
            addr_reg  <= pick ? bus.c1_addr  : bus.c0_addr;
            wdata_reg <= pick ? bus.c1_wdata : bus.c0_wdata;
            cnt_reg   <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt_reg != 2'd0) cnt_reg <= cnt_reg - 2'd1;
          if (access_last) begin
            last_grant_reg <= grant_reg;
            if (!we_reg) rdata_reg[grant_reg] <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory bus is quiet outside ACCESS so stale latched values never leak out.
  assign bus.mem_en    = (state_reg == ACCESS);
  assign bus.mem_we    = bus.mem_en & we_reg;
  assign bus.mem_addr  = bus.mem_en ? addr_reg  : '0;
  assign bus.mem_wdata = bus.mem_en ? wdata_reg : '0;

  assign bus.c0_ack   = (state_reg == DONE) && !grant_reg;
  assign bus.c1_ack   = (state_reg == DONE) &&  grant_reg;
  assign bus.c0_rdata = rdata_reg[0];
  assign bus.c1_rdata = rdata_reg[1];

`ifndef SYNTHESIS
  a_ack_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.c0_ack && bus.c1_ack));
  a_en_access: assert property (@(posedge clk) disable iff (reset)
    bus.mem_en |-> (state_reg == ACCESS));
`endif

endmodule
